// File: rtl/mips_avalon_master_bridge.sv
// mips_avalon_master_bridge
//
// Turns single-outstanding CPU load/store requests into Avalon-MM master
// transactions. Word-aligns the address and builds the byte lanes and the
// replicated write data. Keeps the bus stable while waitrequest is high.
// Returns load data extracted from the addressed lane, with optional sign
// extension.
//
// Parameters:
//   MAX_WAIT    stall cycles tolerated before aborting with an error (0 = no limit)
//   WAIT_W      width of the stall counter; MAX_WAIT < 2**WAIT_W
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid / req_ready       CPU request handshake
//   req_write, req_addr,
//   req_size, req_signed,
//   req_wdata                   CPU request fields, sampled on accept only
//   resp_valid, resp_rdata,
//   resp_err                    one-cycle completion pulse with result
//   address, read, write,
//   writedata, byteenable       Avalon-MM master command
//   waitrequest, readdata       Avalon-MM slave response
module mips_avalon_master_bridge #(
  parameter int unsigned MAX_WAIT = 0,
  parameter int unsigned WAIT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e              state_q, state_d;
  logic [31:0]         address_q, address_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic                is_write_q, is_write_d;
  logic [1:0]          size_q, size_d;
  logic                sgn_q, sgn_d;
  logic [1:0]          off_q, off_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic                req_err;
  logic [3:0]          req_be;
  logic [31:0]         req_wd;
  logic [31:0]         shifted;
  logic [31:0]         load_val;

  // Request decode: error classification and lane generation.
  always_comb begin
    req_err = (req_size == 2'b11) ||
              (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    unique case (req_size)
      2'b00: begin
        req_be = 4'b0001 << req_addr[1:0];
        req_wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wd = {2{req_wdata[15:0]}};
      end
      default: begin
        req_be = 4'b1111;
        req_wd = req_wdata;
      end
    endcase
  end

  // Load lane extraction; for words off_q is always 0 so shifted == readdata.
  always_comb begin
    shifted = readdata >> {off_q, 3'b000};
    unique case (size_q)
      2'b00:   load_val = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      address_q  <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      is_write_q <= 1'b0;
      size_q     <= '0;
      sgn_q      <= 1'b0;
      off_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      address_q  <= address_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      is_write_q <= is_write_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      off_q      <= off_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    address_d  = address_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    is_write_d = is_write_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    off_d      = off_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    wait_d     = wait_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && !rst) begin
          rdata_d = '0;
          wait_d  = '0;
          if (req_err) begin
            // Rejected before reaching the bus; bus registers stay untouched.
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            err_d      = 1'b0;
            address_d  = {req_addr[31:2], 2'b00};
            wdata_d    = req_wd;
            be_d       = req_be;
            is_write_d = req_write;
            size_d     = req_size;
            sgn_d      = req_signed;
            off_d      = req_addr[1:0];
            state_d    = StBus;
          end
        end
      end
      StBus: begin
        if (!waitrequest) begin
          rdata_d = is_write_q ? 32'h0 : load_val;
          err_d   = 1'b0;
          state_d = StResp;
        end else begin
          wait_d = wait_q + 1'b1;
          if (MAX_WAIT != 0 && wait_d == WAIT_W'(MAX_WAIT)) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs. read/write decode from state so reset drops them immediately.
  always_comb begin
    req_ready  = (state_q == StIdle) && !rst;
    read       = (state_q == StBus) && !is_write_q;
    write      = (state_q == StBus) && is_write_q;
    address    = address_q;
    writedata  = wdata_q;
    byteenable = be_q;
    resp_valid = (state_q == StResp);
    resp_rdata = (state_q == StResp) ? rdata_q : 32'h0;
    resp_err   = (state_q == StResp) && err_q;
  end

endmodule

// File: tb/tb_mips_avalon_master_bridge.sv
module tb_mips_avalon_master_bridge;

  localparam int unsigned MW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;

  always #5 clk = ~clk;

  mips_avalon_master_bridge #(.MAX_WAIT(MW), .WAIT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'h12345678 ^ 32'(32'h01010101 * i);
  endfunction

  // Slave: 16-word memory, stalls stall_k cycles per transaction.
  logic [31:0] mem [16];
  int stall_k = 0;
  int stall_cnt = 0;
  assign waitrequest = (read || write) && (stall_cnt < stall_k);
  assign readdata = mem[address[5:2]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      stall_cnt <= 0;
    end else if (read || write) begin
      if (waitrequest) stall_cnt <= stall_cnt + 1;
      else begin
        stall_cnt <= 0;
        if (write)
          for (int b = 0; b < 4; b++)
            if (byteenable[b]) mem[address[5:2]][8*b +: 8] <= writedata[8*b +: 8];
      end
    end else stall_cnt <= 0;
  end

  // Reference model.
  logic [31:0] ref_mem [16];

  function automatic logic model_err(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd3) || (s == 2'd1 && (a % 2) != 0) || (s == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] s);
    int off;
    off = int'(a % 4);
    if (s == 2'd0) return 4'(1 << off);
    if (s == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wd(input logic [31:0] w, input logic [1:0] s);
    if (s == 2'd0) return (w % 256) * 32'h01010101;
    if (s == 2'd1) return (w % 65536) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] a,
                                             input logic [1:0] s, input logic sg);
    logic [31:0] v;
    v = word >> (8 * (a % 4));
    if (s == 2'd0) begin
      v = v % 256;
      if (sg && v >= 128) v = v - 256;
    end else if (s == 2'd1) begin
      v = v % 65536;
      if (sg && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  task automatic xact(input logic wr, input logic [31:0] a, input logic [1:0] s, input logic sg,
                      input logic [31:0] wd, input int k, input logic [31:0] exp_rd,
                      input logic exp_err, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                      input string tag);
    int lat, bus_cyc, wait_n, exp_lat, exp_bus;
    logic serr;
    serr = model_err(a, s);
    if (serr) begin
      exp_lat = 1; exp_bus = 0;
    end else if (k >= int'(MW)) begin
      exp_lat = MW + 1; exp_bus = MW;
    end else begin
      exp_lat = k + 2; exp_bus = k + 1;
    end
    wait_n = 0;
    while (!req_ready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    chk({tag, " ready"}, req_ready, 1);
    stall_k = k;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_size = s; req_signed = sg;
    req_wdata = wd;
    @(negedge clk);
    // Scramble inputs after accept; the bridge must use its own copy.
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
    req_size = 2'($urandom); req_signed = 1'($urandom); req_wdata = $urandom;
    lat = 1;
    bus_cyc = 0;
    while (!resp_valid && lat < 60) begin
      if (read || write) begin
        bus_cyc++;
        chk({tag, " rw"}, {read, write}, wr ? 2'b01 : 2'b10);
        chk({tag, " address"}, address, {a[31:2], 2'b00});
        chk({tag, " byteenable"}, byteenable, exp_be);
        if (wr) chk({tag, " writedata"}, writedata, exp_wd);
      end
      @(negedge clk);
      lat++;
    end
    chk({tag, " resp_valid"}, resp_valid, 1);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " bus cycles"}, bus_cyc, exp_bus);
    chk({tag, " resp_err"}, resp_err, exp_err);
    chk({tag, " resp_rdata"}, resp_rdata, exp_rd);
    if (wr && !exp_err)
      for (int b = 0; b < 4; b++)
        if (exp_be[b]) ref_mem[a[5:2]][8*b +: 8] = exp_wd[8*b +: 8];
    @(negedge clk);
    chk({tag, " pulse end"}, resp_valid, 0);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [1:0]  s;
    logic        sg;
    logic [31:0] wd;
    int          k;
    logic [31:0] rd;
    logic        err;
    logic [3:0]  be;
    logic [31:0] ewd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1'b1, 32'hBFC00004, 2'd2, 1'b0, 32'h00000420, 2,  32'h0,        1'b0, 4'hF, 32'h00000420};
    tbl[1]  = '{1'b1, 32'hBFC00004, 2'd2, 1'b0, 32'h80112233, 0,  32'h0,        1'b0, 4'hF, 32'h80112233};
    tbl[2]  = '{1'b0, 32'hBFC00007, 2'd0, 1'b1, 32'h0,        1,  32'hFFFFFF80, 1'b0, 4'h8, 32'h0};
    tbl[3]  = '{1'b0, 32'hBFC00007, 2'd0, 1'b0, 32'h0,        0,  32'h00000080, 1'b0, 4'h8, 32'h0};
    tbl[4]  = '{1'b1, 32'hBFC00002, 2'd1, 1'b0, 32'h0000BEEF, 3,  32'h0,        1'b0, 4'hC, 32'hBEEFBEEF};
    tbl[5]  = '{1'b0, 32'hBFC00000, 2'd2, 1'b0, 32'h0,        0,  32'hBEEF5678, 1'b0, 4'hF, 32'h0};
    tbl[6]  = '{1'b0, 32'hBFC00001, 2'd2, 1'b0, 32'h0,        0,  32'h0,        1'b1, 4'hF, 32'h0};
    tbl[7]  = '{1'b0, 32'hBFC00000, 2'd3, 1'b0, 32'h0,        0,  32'h0,        1'b1, 4'hF, 32'h0};
    tbl[8]  = '{1'b0, 32'hBFC00004, 2'd2, 1'b0, 32'h0,        10, 32'h0,        1'b1, 4'hF, 32'h0};
    tbl[9]  = '{1'b0, 32'hBFC00004, 2'd2, 1'b0, 32'h0,        0,  32'h80112233, 1'b0, 4'hF, 32'h0};
    tbl[10] = '{1'b0, 32'hBFC00006, 2'd1, 1'b1, 32'h0,        1,  32'hFFFF8011, 1'b0, 4'hC, 32'h0};
    tbl[11] = '{1'b0, 32'hBFC00005, 2'd0, 1'b1, 32'h0,        0,  32'h00000022, 1'b0, 4'h2, 32'h0};

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0; req_signed = 1'b0;
    req_wdata = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge clk);
    chk("reset read", read, 0);
    chk("reset write", write, 0);
    chk("reset address", address, 0);
    chk("reset writedata", writedata, 0);
    chk("reset byteenable", byteenable, 0);
    chk("reset resp_valid", resp_valid, 0);
    chk("reset resp_err", resp_err, 0);
    chk("reset resp_rdata", resp_rdata, 0);
    rst = 1'b0;
    #1;
    chk("reset req_ready", req_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      xact(tbl[i].wr, tbl[i].a, tbl[i].s, tbl[i].sg, tbl[i].wd, tbl[i].k, tbl[i].rd,
           tbl[i].err, tbl[i].be, tbl[i].ewd, $sformatf("vec%0d", i));

    // Reset during a stalled read.
    stall_k = 100;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hBFC00000; req_size = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("midbus read before reset", read, 1);
    rst = 1'b1;
    #1;
    chk("midbus read dropped", read, 0);
    chk("midbus write dropped", write, 0);
    chk("midbus no resp", resp_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midbus resp during reset", resp_valid, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    #1;
    chk("midbus ready after reset", req_ready, 1);
    @(negedge clk);
    chk("midbus no late resp", resp_valid, 0);
    xact(1'b0, 32'hBFC00008, 2'd2, 1'b0, 32'h0, 0, ref_mem[2], 1'b0, 4'hF, 32'h0, "post-reset");

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      logic        wr, sg, e;
      logic [31:0] a, wd, rd;
      logic [1:0]  s;
      int          k;
      wr = 1'($urandom);
      sg = 1'($urandom);
      s  = 2'($urandom_range(0, 3));
      a  = 32'hBFC00000 | ($urandom & 32'h3F);
      if (s == 2'd2 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if (s == 2'd1 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
      wd = $urandom;
      k  = $urandom_range(0, 5);
      e  = model_err(a, s) || (k >= int'(MW));
      rd = (wr || e) ? 32'h0 : model_load(ref_mem[a[5:2]], a, s, sg);
      xact(wr, a, s, sg, wd, k, rd, e, model_be(a, s), model_wd(wd, s),
           $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound the run in case of a hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mips_avalon_master_bridge.md
Name: mips_avalon_master_bridge

Overview:
Converts the CPU's single-outstanding load/store requests into Avalon-MM master transactions for mips_avalon_slave. Sits directly upstream of the slave.
- Aligns addresses, generates byteenable and replicated writedata.
- Holds the bus stable under waitrequest.
- Returns lane-extracted, optionally sign-extended load data to the CPU.

Parameters:
MAX_WAIT, 0, waitrequest cycles tolerated before abort with error; 0 disables the watchdog.
WAIT_W, 16, width of the wait counter; MAX_WAIT < 2^WAIT_W.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  CPU request present
req_ready  out  1  bridge idle, request accepted when req_valid&&req_ready
req_write  in  1  1=store, 0=load
req_addr  in  32  byte address
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  sign-extend load result (byte/half only)
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result; 0 for stores and errors
resp_err  out  1  misaligned, illegal size or timeout; valid with resp_valid
address  out  32  Avalon word address {req_addr[31:2],2'b00}
read  out  1  Avalon read
write  out  1  Avalon write
writedata  out  32  Avalon write data
byteenable  out  4  Avalon byte lanes, bit i = bits 8i+7:8i (little-endian lanes)
waitrequest  in  1  Avalon stall
readdata  in  32  Avalon read data

Behaviour:
- Reset (async): state IDLE; read=write=0; address=writedata=0; byteenable=0; resp_valid=resp_err=0; resp_rdata=0; wait counter=0. req_ready=1 once rst deasserts.
- States: IDLE, BUS, RESP.
- IDLE: req_ready=1.
  - On accept with a legal, aligned request: register address/byteenable/writedata, assert read or write, go to BUS. The bus is driven from the cycle after accept.
  - On accept with an error: go to RESP with err=1 and no bus access.
- Error cases: size=11; half with addr[0]=1; word with addr[1:0]!=0.
- Lane rules:
  - Byte: byteenable=1<<addr[1:0]; writedata={4{wdata[7:0]}}.
  - Half: byteenable=0011 if addr[1]=0, else 1100; writedata={2{wdata[15:0]}}.
  - Word: byteenable=1111; writedata=wdata.
- BUS: req_ready=0. address, read, write, writedata and byteenable are held constant while waitrequest=1.
  - At the first cycle with waitrequest=0, the transaction completes: deassert read/write next cycle, go to RESP.
  - For a read, readdata is captured in that same cycle, shifted right by 8*addr[1:0], then masked to the size.
  - Sign extension: if req_signed, extend from bit 7 (byte) or bit 15 (half). Word ignores req_signed.
- Watchdog (MAX_WAIT>0): counter increments each BUS cycle with waitrequest=1. When it reaches MAX_WAIT, drop read/write, go to RESP with err=1 and rdata=0.
- RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_err, then IDLE. req_ready=0 in RESP, so the earliest next accept is the cycle after resp_valid.
- Latency, zero-wait slave: accept at N, bus at N+1, resp_valid at N+2.
- Latency, slave with waitrequest high for k cycles: resp_valid at N+2+k.
- Error latency: resp_valid at N+1, and read/write never assert.
- req_* inputs are ignored outside IDLE. The bridge keeps its own registered copy; the CPU may change inputs after accept.
- Never asserts read and write together. At most one transaction is outstanding.
- Reset mid-BUS drops read/write asynchronously; no resp_valid is produced for the aborted request.

Test Plan:
- Word store 0x00000420 at 0xBFC00004, slave READ_DELAY=2 -> write=1, address=0xBFC00004, byteenable=1111 held for all waitrequest cycles; one resp_valid, err=0.
- Byte load, signed, addr 0xBFC00007, readdata 0x80112233 -> byteenable=1000; resp_rdata=0xFFFFFF80. Repeat unsigned -> 0x00000080.
- Half store 0xBEEF at 0xBFC00002 -> byteenable=1100, writedata=0xBEEFBEEF; the following word read returns 0xBEEFxxxx with low half unchanged.
- Misaligned word load at 0xBFC00001, and size=11 -> resp_valid at N+1 with err=1, rdata=0; read/write stay 0.
- MAX_WAIT=4, waitrequest held high -> read drops after 4 stall cycles; resp_err=1; the next request is accepted normally.
- Assert rst during BUS -> read/write=0 immediately with no resp_valid; after reset a zero-wait word load completes in 2 cycles.
